// File: rtl/nios_setup_oci_dct_ctrl_if.sv
// Trace-path bundle for the DCT sequencer. It carries the atom input
// handshake, the flush and end-of-test controls, the frame output handshake,
// and the status observed by the OCI test bench.
//   master : trace source, frame sink and test bench (drives the inputs)
//   slave  : nios_setup_oci_dct_ctrl (drives atom_ready, the frame and the status)
interface nios_setup_oci_dct_ctrl_if;
    logic        trace_enable;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        atom_ready;
    logic        flush;
    logic        test_ending;
    logic        frame_valid;
    logic        frame_ready;
    logic [35:0] frame_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [7:0]  drop_count;
    logic        overflow;
    logic        test_has_ended;

    modport master (
        output trace_enable, atom_valid, atom, flush, test_ending, frame_ready,
        input  atom_ready, frame_valid, frame_data, dct_buffer, dct_count,
               drop_count, overflow, test_has_ended
    );

    modport slave (
        input  trace_enable, atom_valid, atom, flush, test_ending, frame_ready,
        output atom_ready, frame_valid, frame_data, dct_buffer, dct_count,
               drop_count, overflow, test_has_ended
    );
endinterface

// File: rtl/nios_setup_oci_dct_ctrl.sv
// Nios II OCI data-capture-trace sequencer. The block packs 2-bit atoms into
// a 30-bit buffer, with the newest atom in the LSBs. A full buffer, a flush
// or the end of the test turns the buffer into a tagged 36-bit frame
// {tag, count, buffer}. Each frame goes out over a valid/ready handshake.
// The block counts dropped atoms and reports when the trace has fully drained.
// Ports:
//   clk   : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : slave side of nios_setup_oci_dct_ctrl_if
//           (atom in, frame out, flush/test_ending, status)
module nios_setup_oci_dct_ctrl #(
    parameter int MAX_ATOMS = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    nios_setup_oci_dct_ctrl_if.slave bus
);
    localparam int BUF_W = 2 * MAX_ATOMS;

    typedef enum logic [1:0] {COLLECT, EMIT, DONE} state_t;

    state_t            state_reg;
    logic [BUF_W-1:0]  buffer_reg;
    logic [3:0]        count_reg;
    logic [35:0]       frame_reg;
    logic              frame_valid_reg;
    logic [7:0]        drop_count_reg;
    logic              overflow_reg;
    logic              ended_reg;
    logic              end_seen_reg;   // test_ending observed while a frame was pending

    logic              accept;
    logic              drop;
    logic [BUF_W-1:0]  buffer_next;
    logic [3:0]        count_next;

    // The source cannot stall, so readiness is visible in the same cycle.
    assign bus.atom_ready = (state_reg == COLLECT) && bus.trace_enable;
    assign accept         = bus.atom_ready && bus.atom_valid;
    // Only EMIT can refuse an enabled atom. DONE ignores its inputs entirely.
    assign drop           = (state_reg == EMIT) && bus.atom_valid && bus.trace_enable;

    always_comb begin
        buffer_next = buffer_reg;
        count_next  = count_reg;
        if (accept) begin
            buffer_next = {buffer_reg[BUF_W-3:0], bus.atom};
            count_next  = count_reg + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= COLLECT;
            buffer_reg      <= '0;
            count_reg       <= '0;
            frame_reg       <= '0;
            frame_valid_reg <= 1'b0;
            drop_count_reg  <= '0;
            overflow_reg    <= 1'b0;
            ended_reg       <= 1'b0;
            end_seen_reg    <= 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    buffer_reg <= buffer_next;
                    count_reg  <= count_next;
                    end_seen_reg <= 1'b0;
                    // The frame snapshot uses the post-accept values, so an
                    // atom arriving together with a flush is included.
                    if (accept && count_next == 4'(MAX_ATOMS)) begin
                        frame_reg       <= {2'b10, count_next, buffer_next};
                        frame_valid_reg <= 1'b1;
                        end_seen_reg    <= bus.test_ending;
                        state_reg       <= EMIT;
                    end else if ((bus.flush || bus.test_ending) && count_next != 4'd0) begin
                        frame_reg       <= {2'b11, count_next, buffer_next};
                        frame_valid_reg <= 1'b1;
                        end_seen_reg    <= bus.test_ending;
                        state_reg       <= EMIT;
                    end else if (bus.test_ending) begin
                        ended_reg <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                EMIT: begin
                    if (drop) begin
                        overflow_reg <= 1'b1;
                        if (drop_count_reg != 8'hFF)
                            drop_count_reg <= drop_count_reg + 8'd1;
                    end
                    if (bus.test_ending)
                        end_seen_reg <= 1'b1;
                    if (bus.frame_ready) begin
                        buffer_reg      <= '0;
                        count_reg       <= '0;
                        frame_valid_reg <= 1'b0;
                        if (bus.test_ending || end_seen_reg) begin
                            ended_reg <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= COLLECT;
                        end
                    end
                end
                DONE: begin
                    // Terminal state; only reset leaves it.
                end
                default: state_reg <= COLLECT;
            endcase
        end
    end

    assign bus.frame_valid    = frame_valid_reg;
    assign bus.frame_data     = frame_reg;
    assign bus.dct_buffer     = buffer_reg;
    assign bus.dct_count      = count_reg;
    assign bus.drop_count     = drop_count_reg;
    assign bus.overflow       = overflow_reg;
    assign bus.test_has_ended = ended_reg;
endmodule

// File: tb/tb_nios_setup_oci_dct_ctrl.sv
module tb_nios_setup_oci_dct_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;

    nios_setup_oci_dct_ctrl_if bus_if();

    nios_setup_oci_dct_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [35:0] exp_q[$];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // The monitor samples on the falling edge. A visible valid&ready means the
    // handshake completes at the next rising edge, so each frame is popped once.
    always @(negedge clk) begin
        if (!reset && bus_if.frame_valid && bus_if.frame_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL frame: unexpected frame %h", bus_if.frame_data);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if (bus_if.frame_data !== e) begin
                    n_err++;
                    $display("FAIL frame: got %h, expected %h", bus_if.frame_data, e);
                end else begin
                    $display("ok   frame: %h", bus_if.frame_data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put_atom(input logic [1:0] a);
        bus_if.atom_valid = 1'b1;
        bus_if.atom       = a;
        step();
        bus_if.atom_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        bus_if.trace_enable = 1'b0;
        bus_if.atom_valid   = 1'b0;
        bus_if.atom         = 2'd0;
        bus_if.flush        = 1'b0;
        bus_if.test_ending  = 1'b0;
        bus_if.frame_ready  = 1'b1;
        step();
        step();
        // Reset state: every output is 0 while reset is held.
        chk("rst_frame_valid", 36'(bus_if.frame_valid), 36'd0);
        chk("rst_count", 36'(bus_if.dct_count), 36'd0);
        chk("rst_buffer", 36'(bus_if.dct_buffer), 36'd0);
        chk("rst_drop", 36'(bus_if.drop_count), 36'd0);
        chk("rst_ended", 36'(bus_if.test_has_ended), 36'd0);
        reset = 1'b0;
        step();
        chk("ready_disabled", 36'(bus_if.atom_ready), 36'd0);
        bus_if.trace_enable = 1'b1;

        // Full frame: 15 atoms 0,1,2,3,... with the last atom (2) in the LSBs.
        exp_q.push_back({2'b10, 4'd15, 30'b00_01_10_11_00_01_10_11_00_01_10_11_00_01_10});
        for (int i = 0; i < 15; i++) put_atom(2'(i % 4));
        chk("full_valid", 36'(bus_if.frame_valid), 36'd1);
        chk("full_ready_low", 36'(bus_if.atom_ready), 36'd0);
        step();
        chk("full_count_cleared", 36'(bus_if.dct_count), 36'd0);
        chk("full_ready_back", 36'(bus_if.atom_ready), 36'd1);
        chk("full_drop", 36'(bus_if.drop_count), 36'd0);

        // Flush after 3 atoms.
        exp_q.push_back({2'b11, 4'd3, 24'b0, 6'b111001});
        put_atom(2'd3); put_atom(2'd2); put_atom(2'd1);
        chk("pre_flush_count", 36'(bus_if.dct_count), 36'd3);
        bus_if.flush = 1'b1;
        step();
        bus_if.flush = 1'b0;
        step();

        // Stalled EMIT: 10 cycles of offered atoms are all dropped.
        bus_if.frame_ready = 1'b0;
        exp_q.push_back({2'b11, 4'd2, 26'b0, 4'b1011});
        put_atom(2'd2); put_atom(2'd3);
        bus_if.flush = 1'b1;
        step();
        bus_if.flush = 1'b0;
        bus_if.atom_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        bus_if.atom_valid = 1'b0;
        chk("stall_drop10", 36'(bus_if.drop_count), 36'd10);
        chk("stall_overflow", 36'(bus_if.overflow), 36'd1);
        chk("stall_data_stable", bus_if.frame_data, {2'b11, 4'd2, 26'b0, 4'b1011});
        bus_if.frame_ready = 1'b1;
        step();

        // An atom and a flush in the same cycle with 4 atoms held.
        exp_q.push_back({2'b11, 4'd5, 20'b0, 10'b01_10_11_00_11});
        put_atom(2'd1); put_atom(2'd2); put_atom(2'd3); put_atom(2'd0);
        bus_if.flush = 1'b1;
        put_atom(2'd3);
        bus_if.flush = 1'b0;
        step();
        chk("same_cycle_drop", 36'(bus_if.drop_count), 36'd10);

        // Saturation, then a reset during EMIT (the pending frame is discarded).
        bus_if.frame_ready = 1'b0;
        bus_if.flush = 1'b1;
        put_atom(2'd2);
        bus_if.flush = 1'b0;
        bus_if.atom_valid = 1'b1;
        for (int i = 0; i < 300; i++) step();
        bus_if.atom_valid = 1'b0;
        chk("sat_drop255", 36'(bus_if.drop_count), 36'd255);
        chk("sat_valid", 36'(bus_if.frame_valid), 36'd1);
        reset = 1'b1;
        #1;
        chk("async_frame_valid", 36'(bus_if.frame_valid), 36'd0);
        chk("async_drop", 36'(bus_if.drop_count), 36'd0);
        chk("async_overflow", 36'(bus_if.overflow), 36'd0);
        chk("async_count", 36'(bus_if.dct_count), 36'd0);
        step();
        reset = 1'b0;
        bus_if.frame_ready = 1'b1;
        step();
        chk("post_reset_collect", 36'(bus_if.atom_ready), 36'd1);

        // test_ending with an empty buffer: DONE one cycle later, no frame.
        bus_if.test_ending = 1'b1;
        chk("empty_end_before", 36'(bus_if.test_has_ended), 36'd0);
        step();
        chk("empty_end_after", 36'(bus_if.test_has_ended), 36'd1);
        chk("empty_end_noframe", 36'(bus_if.frame_valid), 36'd0);
        bus_if.test_ending = 1'b0;
        pulse_reset();

        // test_ending with 7 atoms held: a partial frame, then DONE.
        exp_q.push_back({2'b11, 4'd7, 16'b0, 14'b01010101010101});
        for (int i = 0; i < 7; i++) put_atom(2'd1);
        bus_if.test_ending = 1'b1;
        step();
        chk("end_frame_valid", 36'(bus_if.frame_valid), 36'd1);
        step();
        chk("end_has_ended", 36'(bus_if.test_has_ended), 36'd1);
        bus_if.atom_valid = 1'b1;
        for (int i = 0; i < 5; i++) step();
        bus_if.atom_valid = 1'b0;
        chk("done_ready", 36'(bus_if.atom_ready), 36'd0);
        chk("done_count", 36'(bus_if.dct_count), 36'd0);
        chk("done_drop", 36'(bus_if.drop_count), 36'd0);
        chk("done_frame_valid", 36'(bus_if.frame_valid), 36'd0);

        chk("scoreboard_empty", 36'(exp_q.size()), 36'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/nios_setup_oci_dct_ctrl.md
# nios_setup_oci_dct_ctrl

Sequencer for the Nios II on-chip-instrumentation data-capture-trace (DCT) buffer. Packs 2-bit trace atoms into the 30-bit `dct_buffer` / 4-bit `dct_count` pair, then emits a tagged 36-bit frame to the trace memory over a valid/ready handshake. Flushes partial frames on request or at end of test, counts dropped atoms, and raises `test_has_ended` once trace is fully drained. Sits between the OCI trace source and the trace RAM writer; `dct_buffer`, `dct_count`, `test_ending` and `test_has_ended` feed the OCI test bench.

## Interface
- `MAX_ATOMS`, 15, atoms per full frame; buffer width is 2*MAX_ATOMS = 30.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `trace_enable`  in  1  trace capture enable; atoms are ignored while low.
- `atom_valid`  in  1  atom offered this cycle; the source cannot stall.
- `atom`  in  2  trace atom code.
- `atom_ready`  out  1  high when an offered atom will be accepted.
- `flush`  in  1  single-cycle pulse; emit a partial frame.
- `test_ending`  in  1  level; drain and stop.
- `frame_valid`  out  1  frame presented.
- `frame_ready`  in  1  trace RAM writer accepts the frame.
- `frame_data`  out  36  {tag[1:0], count[3:0], buffer[29:0]}.
- `dct_buffer`  out  30  live packing buffer.
- `dct_count`  out  4  atoms currently held, 0..15.
- `drop_count`  out  8  dropped atoms, saturating at 255.
- `overflow`  out  1  sticky; set on the first drop.
- `test_has_ended`  out  1  drain complete.

## Operation
- States: COLLECT, EMIT, DONE. Reset enters COLLECT; all outputs reset to 0.
- COLLECT: `atom_ready` = `trace_enable`. On accept, `dct_buffer` <= {`dct_buffer`[27:0], `atom`} (newest atom in the LSBs), `dct_count` +1.
  - Accepted atom raises the count to 15 -> latch frame with tag 2'b10, go to EMIT.
  - `flush` or `test_ending` with post-accept count > 0 -> latch frame with tag 2'b11, go to EMIT. An atom accepted in the same cycle is included in the frame.
  - `test_ending` with count 0 -> DONE.
- EMIT: `frame_valid` = 1; `frame_data` stays stable until accepted; `atom_ready` = 0. When `frame_valid` & `frame_ready`: clear `dct_buffer` and `dct_count`, then go to DONE if `test_ending` is high or was seen while in EMIT, otherwise to COLLECT. `flush` in EMIT is ignored.
- Drop: `atom_valid` & `trace_enable` & !`atom_ready` -> `drop_count` +1 (saturating), `overflow` <= 1. An atom offered while `trace_enable` = 0 is not a drop.
- DONE: `test_has_ended` = 1; `atom_ready` = 0 and `frame_valid` = 0; inputs are ignored and no drops are counted. DONE exits only on reset.
- A reset during EMIT discards the pending frame and drops `frame_valid` asynchronously.

## Timing
- Accepting an atom at edge N updates `dct_buffer`/`dct_count` at edge N.
- The 15th atom or a `flush` at edge N -> `frame_valid` high in cycle N+1.
- Handshake at edge M -> count 0 and `atom_ready` high from cycle M+1 (if enabled). Minimum frame period is 16 cycles when atoms arrive back to back; atoms offered during EMIT are dropped.
- `test_has_ended` rises one cycle after the final handshake, or one cycle after `test_ending` is sampled with an empty buffer.

## Test plan
- Reset, then 15 back-to-back atoms 0,1,2,3,0,1,… with `frame_ready` = 1 -> one frame with tag 2'b10, count 15, buffer[1:0] = 2 (last atom), buffer[29:28] = 0; `drop_count` = 0.
- 3 atoms (3,2,1), then `flush` -> frame_data = {2'b11, 4'd3, 24'b0, 6'b111001}.
- Hold `frame_ready` = 0 for 10 cycles in EMIT while offering atoms every cycle -> `frame_data` stable, `drop_count` = 10, `overflow` = 1; 300 such drops -> `drop_count` = 255.
- An atom and `flush` in the same cycle with 4 atoms held -> frame count 5, new atom in buffer[1:0].
- `test_ending` with 7 atoms held -> partial frame; after its handshake `test_has_ended` = 1 and later atoms are ignored. `test_ending` with 0 atoms held -> `test_has_ended` one cycle later, no frame emitted.
- Assert `reset` mid-EMIT -> `frame_valid`, counters and `overflow` all 0 immediately; state returns to COLLECT.
